// File: rtl/frame_uart_pkg.sv
// Shared types and constants for the frame UART transmitter.
// Optional build macro: FRAME_CSUM_EN appends an XOR checksum byte per frame.
package frame_uart_pkg;

  // Start + 8 data + stop
  localparam int UART_FRAME_BITS = 10;
  localparam int FRAME_LEN_DEF   = 76800;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    WAIT_RD,
    START,
    DATA,
    STOP,
    NEXT,
    DONE
`ifdef FRAME_CSUM_EN
    , CSUM_FETCH
`endif
  } state_e;

endpackage

// File: rtl/frame_uart_tx_if.sv
// Frame-memory read port: 1-cycle read latency, data valid the cycle after mem_en_o.
interface frame_uart_tx_if #(
  parameter int ADDR_W = 17
) ();
  logic              mem_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_data_i;

  modport master (output mem_en_o, output mem_addr_o, input mem_data_i);
  modport slave  (input mem_en_o, input mem_addr_o, output mem_data_i);
endinterface

// File: rtl/frame_uart_tx_serializer.sv
// 8N1 serializer: baud counter, bit counter, shift register and registered line driver.
// load_i is accepted only while busy_o is low; the line goes low one edge after the load.
module uart_tx_serializer
  import frame_uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [15:0]       baud_i,     // cycles per bit, never 0
  output logic              busy_o,
  output logic              bit_end_o,  // last cycle of the current bit
  output logic [3:0]        bit_idx_o,  // 0 = start, 1..8 = data, 9 = stop
  output logic              tx_o
);

  localparam logic [3:0] LAST_BIT = 4'(UART_FRAME_BITS - 1);

  logic              active_q, active_d;
  logic [15:0]       baud_cnt_q, baud_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              bit_end;
  logic              line_bit;

  // Bit timing, shifting and the next line level
  always_comb begin
    active_d   = active_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    bit_end    = active_q && (baud_cnt_q == baud_i - 16'd1);

    if (bit_cnt_q == 4'd0)          line_bit = 1'b0;
    else if (bit_cnt_q == LAST_BIT) line_bit = 1'b1;
    else                            line_bit = shift_q[0];

    tx_d = active_q ? line_bit : 1'b1;

    if (!active_q) begin
      if (load_i) begin
        active_d   = 1'b1;
        shift_d    = data_i;
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    end else if (bit_end) begin
      baud_cnt_d = '0;
      if (bit_cnt_q == LAST_BIT) begin
        active_d  = 1'b0;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        // The start bit does not consume a data bit
        if (bit_cnt_q != 4'd0) shift_d = shift_q >> 1;
      end
    end else begin
      baud_cnt_d = baud_cnt_q + 16'd1;
    end
  end

  // State registers; reset forces the line high on the same edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q   <= 1'b0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      active_q   <= active_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  assign busy_o    = active_q;
  assign bit_end_o = bit_end;
  assign bit_idx_o = bit_cnt_q;
  assign tx_o      = tx_q;

endmodule

// File: rtl/frame_uart_tx.sv
// Streams FRAME_LEN bytes from a frame memory out of an 8N1 UART, one frame per start pulse.
// Optional build macro: FRAME_CSUM_EN sends an XOR-of-payload byte after the last payload byte.
module frame_uart_tx
  import frame_uart_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [15:0]       baud_div_i,
  frame_uart_tx_if.master   mem,
  output logic              uart_tx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] byte_cnt_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [15:0]       baud_q, baud_d;
  logic              busy_q, busy_d;
`ifdef FRAME_CSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              csum_phase_q, csum_phase_d;
`endif

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              ser_load;
  logic [7:0]        ser_data;
  logic              ser_busy;
  logic              ser_bit_end;
  logic [3:0]        ser_bit_idx;

  // Frame sequencing: the START/DATA/STOP states track the serializer's bit position
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    byte_cnt_d = byte_cnt_q;
    baud_d     = baud_q;
    busy_d     = busy_q;
`ifdef FRAME_CSUM_EN
    csum_d       = csum_q;
    csum_phase_d = csum_phase_q;
`endif
    mem_en   = 1'b0;
    mem_addr = '0;
    ser_load = 1'b0;
    ser_data = mem.mem_data_i;
    done_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          baud_d     = (baud_div_i == 16'd0) ? 16'd1 : baud_div_i;
          index_d    = '0;
          byte_cnt_d = '0;
          busy_d     = 1'b1;
`ifdef FRAME_CSUM_EN
          csum_d       = '0;
          csum_phase_d = 1'b0;
`endif
          state_d    = FETCH;
        end
      end
      FETCH: begin
        mem_en   = 1'b1;
        mem_addr = index_q;
        state_d  = WAIT_RD;
      end
      WAIT_RD: begin
        if (!ser_busy) begin
          ser_load = 1'b1;
`ifdef FRAME_CSUM_EN
          csum_d   = csum_q ^ mem.mem_data_i;
`endif
          state_d  = START;
        end
      end
      START: if (ser_bit_end) state_d = DATA;
      DATA:  if (ser_bit_end && ser_bit_idx == 4'(DATA_W)) state_d = STOP;
      STOP: begin
        if (ser_bit_end) begin
`ifdef FRAME_CSUM_EN
          if (csum_phase_q) begin
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            state_d = NEXT;
          end
`else
          state_d = NEXT;
`endif
        end
      end
      NEXT: begin
        byte_cnt_d = byte_cnt_q + 1'b1;
        if (index_q == LAST_IDX) begin
`ifdef FRAME_CSUM_EN
          state_d = CSUM_FETCH;
`else
          busy_d  = 1'b0;
          state_d = DONE;
`endif
        end else begin
          index_d = index_q + 1'b1;
          state_d = FETCH;
        end
      end
`ifdef FRAME_CSUM_EN
      CSUM_FETCH: begin
        if (!ser_busy) begin
          ser_load     = 1'b1;
          ser_data     = csum_q;
          csum_phase_d = 1'b1;
          state_d      = START;
        end
      end
`endif
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      index_q    <= '0;
      byte_cnt_q <= '0;
      baud_q     <= 16'd1;
      busy_q     <= 1'b0;
`ifdef FRAME_CSUM_EN
      csum_q       <= '0;
      csum_phase_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      byte_cnt_q <= byte_cnt_d;
      baud_q     <= baud_d;
      busy_q     <= busy_d;
`ifdef FRAME_CSUM_EN
      csum_q       <= csum_d;
      csum_phase_q <= csum_phase_d;
`endif
    end
  end

  uart_tx_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (ser_load),
    .data_i    (ser_data),
    .baud_i    (baud_q),
    .busy_o    (ser_busy),
    .bit_end_o (ser_bit_end),
    .bit_idx_o (ser_bit_idx),
    .tx_o      (uart_tx_o)
  );

  assign mem.mem_en_o   = mem_en;
  assign mem.mem_addr_o = mem_addr;
  assign busy_o         = busy_q;
  assign byte_cnt_o     = byte_cnt_q;

endmodule

// File: tb/tb_frame_uart_tx.sv
// Scoreboard bench for frame_uart_tx: stimulus pushes expected bytes/done events,
// negedge monitors decode the line, the done pulse and memory strobes and compare.
module tb_frame_uart_tx;

  localparam int FRAME_LEN = 3;
  localparam int ADDR_W    = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [15:0]       baud_div = 16'd4;
  logic              uart_tx, busy, done;
  logic [ADDR_W-1:0] byte_cnt;

  frame_uart_tx_if #(.ADDR_W(ADDR_W)) mem_if ();

  frame_uart_tx #(.FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W), .DATA_W(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .baud_div_i (baud_div),
    .mem        (mem_if.master),
    .uart_tx_o  (uart_tx),
    .busy_o     (busy),
    .done_o     (done),
    .byte_cnt_o (byte_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:3];
  always @(posedge clk) if (mem_if.mem_en_o) mem_if.mem_data_i <= mem[mem_if.mem_addr_o[1:0]];

  typedef struct { logic [7:0] data; int fall; } byte_exp_t;
  typedef struct { int at; int cnt; } done_exp_t;
  byte_exp_t byte_q[$];
  done_exp_t done_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  int exp_baud = 4;
  int strobes  = 0;

  // Line monitor: decode 8N1 at bit centres using the expected bit width
  bit         mon_act = 1'b0;
  bit         prev_line = 1'b1;
  int         t0 = 0;
  int         off = 0;
  logic [9:0] bits = '0;
  byte_exp_t  be;
  always @(negedge clk) begin
    if (rst) begin
      mon_act   = 1'b0;
      prev_line = 1'b1;
    end else begin
      if (!mon_act && prev_line && !uart_tx) begin
        mon_act = 1'b1;
        t0      = cyc;
        bits    = '0;
      end
      if (mon_act) begin
        off = cyc - t0;
        for (int k = 0; k < 10; k++) begin
          if (off == k * exp_baud + exp_baud / 2) begin
            bits[k] = uart_tx;
            if (k == 9) begin
              mon_act = 1'b0;
              if (byte_q.size() == 0) begin
                chk("unexpected byte on line", int'(bits[8:1]), -1);
              end else begin
                be = byte_q.pop_front();
                chk("start bit", int'(bits[0]), 0);
                chk("data byte", int'(bits[8:1]), int'(be.data));
                chk("stop bit", int'(bits[9]), 1);
                chk("start bit cycle", t0, be.fall);
              end
            end
          end
        end
      end
      prev_line = uart_tx;
    end
  end

  // Done monitor
  done_exp_t de;
  always @(negedge clk) begin
    if (!rst && done) begin
      if (done_q.size() == 0) begin
        chk("unexpected done_o", 1, 0);
      end else begin
        de = done_q.pop_front();
        chk("done_o cycle", cyc, de.at);
        chk("byte_cnt at done", int'(byte_cnt), de.cnt);
      end
    end
  end

  // Memory monitor: addresses 0,1,2 in order, each strobe a single cycle
  bit prev_en = 1'b0;
  always @(negedge clk) begin
    if (!rst && mem_if.mem_en_o) begin
      chk("mem_addr sequence", int'(mem_if.mem_addr_o), strobes);
      chk("mem_en single cycle", int'(prev_en), 0);
      strobes++;
    end
    prev_en = mem_if.mem_en_o;
  end

  // Issue a start pulse and push the full-frame expectations.
  // With start sampled at edge s, byte k's start bit appears at s+3+k*(10B+3).
  task automatic start_frame(input int bd, input bit full, output int s);
    int eb, per;
    byte_exp_t e;
    done_exp_t d;
    @(negedge clk);
    eb       = (bd == 0) ? 1 : bd;
    per      = 10 * eb + 3;
    exp_baud = eb;
    baud_div = 16'(bd);
    start    = 1'b1;
    strobes  = 0;
    s        = cyc + 1;
    for (int k = 0; k < FRAME_LEN; k++) begin
      e.data = mem[k];
      e.fall = s + 3 + k * per;
      byte_q.push_back(e);
      if (!full) break;
    end
    if (full) begin
`ifdef FRAME_CSUM_EN
      e.data = 8'hF6;  // 0x55 ^ 0xA3 ^ 0x00
      e.fall = s + 2 + 2 * per + 10 * eb + 2 + 1;
      byte_q.push_back(e);
      d.at  = e.fall - 1 + 10 * eb;
`else
      d.at  = s + FRAME_LEN * per;
`endif
      d.cnt = FRAME_LEN;
      done_q.push_back(d);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_o timeout", 0, 1);
  endtask

  task automatic post_checks();
    repeat (4) @(negedge clk);
    chk("busy after done", int'(busy), 0);
    chk("byte_cnt holds", int'(byte_cnt), FRAME_LEN);
    chk("mem strobes per frame", strobes, FRAME_LEN);
    chk("bytes outstanding", byte_q.size(), 0);
    chk("done outstanding", done_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int s;
  int n;
  initial begin
    mem[0] = 8'h55;
    mem[1] = 8'hA3;
    mem[2] = 8'h00;
    mem[3] = 8'hFF;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset uart_tx", int'(uart_tx), 1);
    chk("reset mem_en", int'(mem_if.mem_en_o), 0);
    chk("reset mem_addr", int'(mem_if.mem_addr_o), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset byte_cnt", int'(byte_cnt), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame, 4 cycles per bit
    start_frame(4, 1'b1, s);
    repeat (10) @(negedge clk);
    chk("busy mid-frame", int'(busy), 1);
    wait_done(2000);
    post_checks();

    // Extra start and a baud change mid-frame must both be ignored
    start_frame(4, 1'b1, s);
    repeat (60) @(negedge clk);
    start    = 1'b1;
    baud_div = 16'd8;
    @(negedge clk);
    start    = 1'b0;
    wait_done(2000);
    post_checks();
    repeat (200) @(negedge clk);
    chk("no requeued frame", int'(busy), 0);

    // baud_div 0 behaves as 1 cycle per bit
    start_frame(0, 1'b1, s);
    wait_done(2000);
    post_checks();

    // Reset during data bit 4 of the second byte
    start_frame(4, 1'b0, s);
    n = 0;
    while (cyc < s + 67 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("line low before reset", int'(uart_tx), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort uart_tx high", int'(uart_tx), 1);
    chk("abort busy", int'(busy), 0);
    chk("abort byte_cnt", int'(byte_cnt), 0);
    chk("abort done", int'(done), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort bytes outstanding", byte_q.size(), 0);
    chk("abort strobes", strobes, 2);

    // Full frame again from address 0
    start_frame(4, 1'b1, s);
    wait_done(2000);
    post_checks();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
